// File: rtl/maze_frame_compositor.sv
// Maze game pixel compositor: two-stage colour pipeline plus PLAY/WIN/LOSE/DONE game controller.
// Frame events come from stage-1 pixel overlap and are resolved on the per-frame update pulse.
module maze_frame_compositor #(
  parameter int NUM_LEVELS    = 4,
  parameter int COLOR_BITS    = 8,
  parameter int BORDER_W      = 15,
  parameter int SCREEN_FRAMES = 120,
  parameter logic [3*NUM_LEVELS-1:0] WALL_PALETTE = 12'hB5F,
  localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update,
  input  logic [9:0]            x_count,
  input  logic [9:0]            y_count,
  input  logic                  screen_area,
  input  logic                  player_px,
  input  logic                  wall_px,
  input  logic                  safe_px,
  input  logic                  win_text_px,
  input  logic                  lose_text_px,
  input  logic                  start,
  output logic [LW-1:0]         level,
  output logic [1:0]            game_state,
  output logic                  player_reset,
  output logic [COLOR_BITS-1:0] vga_r,
  output logic [COLOR_BITS-1:0] vga_g,
  output logic [COLOR_BITS-1:0] vga_b
);

  // state | meaning
  // PLAY  | maze shown, hit/goal events collected each frame
  // WIN   | green WIN screen held for SCREEN_FRAMES updates
  // LOSE  | red GAME OVER screen held for SCREEN_FRAMES updates
  // DONE  | last level cleared, white screen until start
  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WIN  = 2'd1,
    ST_LOSE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int CW = (SCREEN_FRAMES > 1) ? $clog2(SCREEN_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SCREEN_FRAMES - 1);
  localparam logic [LW-1:0] LAST_LVL = LW'(NUM_LEVELS - 1);
  localparam logic [9:0]    X_LO     = 10'(BORDER_W);
  localparam logic [9:0]    X_HI     = 10'(640 - BORDER_W);
  localparam logic [9:0]    Y_LO     = 10'(BORDER_W);
  localparam logic [9:0]    Y_HI     = 10'(480 - BORDER_W);

  state_t        state, state_n;
  logic [LW-1:0] level_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          hit_lat, hit_lat_n, goal_lat, goal_lat_n;
  logic          player_reset_n;

  logic s1_screen, s1_player, s1_wall, s1_safe, s1_win_txt, s1_lose_txt, s1_border;
  logic border_c;
  logic hit_now, goal_now;
  logic [2:0] rgb;
  logic [2:0] wall_rgb;

  assign border_c = (x_count < X_LO) | (x_count >= X_HI) |
                    (y_count < Y_LO) | (y_count >= Y_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_screen   <= 1'b0;
      s1_player   <= 1'b0;
      s1_wall     <= 1'b0;
      s1_safe     <= 1'b0;
      s1_win_txt  <= 1'b0;
      s1_lose_txt <= 1'b0;
      s1_border   <= 1'b0;
    end else begin
      s1_screen   <= screen_area;
      s1_player   <= player_px;
      s1_wall     <= wall_px;
      s1_safe     <= safe_px;
      s1_win_txt  <= win_text_px;
      s1_lose_txt <= lose_text_px;
      s1_border   <= border_c;
    end
  end

  assign wall_rgb = WALL_PALETTE[3*int'(level) +: 3];

  always_comb begin
    rgb = 3'b000;
    if (s1_screen) begin
      case (state)
        ST_PLAY: begin
          if (s1_player)      rgb = 3'b010;
          else if (s1_border) rgb = 3'b111;
          else if (s1_wall)   rgb = wall_rgb;
          else if (s1_safe)   rgb = 3'b011;
        end
        ST_WIN:  if (!s1_win_txt)  rgb = 3'b010;
        ST_LOSE: if (!s1_lose_txt) rgb = 3'b100;
        ST_DONE: if (!s1_win_txt)  rgb = 3'b111;
        default: rgb = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      vga_r <= {COLOR_BITS{rgb[2]}};
      vga_g <= {COLOR_BITS{rgb[1]}};
      vga_b <= {COLOR_BITS{rgb[0]}};
    end
  end

  assign hit_now  = (state == ST_PLAY) & s1_screen & s1_player & (s1_wall | s1_border);
  assign goal_now = (state == ST_PLAY) & s1_screen & s1_player & s1_safe;

  // The pixel arriving on the update cycle itself still counts toward this frame.
  always_comb begin
    state_n    = state;
    level_n    = level;
    cnt_n      = cnt;
    hit_lat_n  = hit_lat | hit_now;
    goal_lat_n = goal_lat | goal_now;
    case (state)
      ST_PLAY: begin
        cnt_n = '0;
        if (update) begin
          if (hit_lat_n)       state_n = ST_LOSE;
          else if (goal_lat_n) state_n = ST_WIN;
        end
      end
      ST_WIN: begin
        if (update) begin
          if (cnt == LAST_CNT) begin
            if (level == LAST_LVL) begin
              state_n = ST_DONE;
            end else begin
              state_n = ST_PLAY;
              level_n = level + LW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      ST_LOSE: begin
        if (update) begin
          if (cnt == LAST_CNT) state_n = ST_PLAY;
          else                 cnt_n   = cnt + CW'(1);
        end
      end
      ST_DONE: begin
        if (start) begin
          state_n = ST_PLAY;
          level_n = '0;
        end
      end
      default: state_n = ST_PLAY;
    endcase
    if (update || (state_n != state)) begin
      hit_lat_n  = 1'b0;
      goal_lat_n = 1'b0;
    end
    if (state_n != state) cnt_n = '0;
    player_reset_n = (state_n == ST_PLAY) && (state != ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_PLAY;
      level        <= '0;
      cnt          <= '0;
      hit_lat      <= 1'b0;
      goal_lat     <= 1'b0;
      player_reset <= 1'b0;
    end else begin
      state        <= state_n;
      level        <= level_n;
      cnt          <= cnt_n;
      hit_lat      <= hit_lat_n;
      goal_lat     <= goal_lat_n;
      player_reset <= player_reset_n;
    end
  end

  assign game_state = state;

endmodule
